// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU codes and the E-stage control bundle
// used by the control decode pipeline.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_MUL = 6'd24;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam int ALU_CODE_W = 3;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_MUL = 3'd3,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } aluOp_t;

  typedef struct packed {
    logic   regWrite;
    logic   memToReg;
    logic   memWrite;
    logic   aluSrc;
    logic   regDst;
    aluOp_t aluOp;
    logic   isMul;
  } exCtrl_t;

  localparam exCtrl_t EX_BUBBLE = '{
    regWrite: 1'b0, memToReg: 1'b0, memWrite: 1'b0,
    aluSrc: 1'b0, regDst: 1'b0, aluOp: ALU_AND, isMul: 1'b0
  };

  // Immediate ALU ops all write the register file from the ALU with an immediate operand.
  function automatic exCtrl_t immCtrl(input aluOp_t op);
    exCtrl_t c;
    c          = EX_BUBBLE;
    c.regWrite = 1'b1;
    c.aluSrc   = 1'b1;
    c.aluOp    = op;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational main/ALU decoder. Unknown encodings collapse to an
// all-zero control word with the illegal flag raised.
module ctrl_decode_comb #(
  parameter int EN_EXT = 1
) (
  input  logic       instrValid,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       branch,
  output logic       bne,
  output logic       jump,
  output logic       illegal,
  output logic       regWrite,
  output logic       memToReg,
  output logic       memWrite,
  output logic       aluSrc,
  output logic       regDst,
  output logic [2:0] aluCode,
  output logic       isMul
);
  import mips_pkg::*;

  exCtrl_t ctrl;
  logic    branchRaw;
  logic    bneRaw;
  logic    jumpRaw;
  logic    known;

  always_comb begin
    ctrl      = EX_BUBBLE;
    branchRaw = 1'b0;
    bneRaw    = 1'b0;
    jumpRaw   = 1'b0;
    known     = 1'b1;
    case (op)
      OP_LW: ctrl = '{regWrite: 1'b1, memToReg: 1'b1, memWrite: 1'b0,
                      aluSrc: 1'b1, regDst: 1'b0, aluOp: ALU_ADD, isMul: 1'b0};
      OP_SW: ctrl = '{regWrite: 1'b0, memToReg: 1'b0, memWrite: 1'b1,
                      aluSrc: 1'b1, regDst: 1'b0, aluOp: ALU_ADD, isMul: 1'b0};
      OP_ADDI: ctrl = immCtrl(ALU_ADD);
      OP_BEQ:  branchRaw = 1'b1;
      OP_J:    jumpRaw = 1'b1;
      OP_RTYPE: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
        case (funct)
          FN_AND: ctrl.aluOp = ALU_AND;
          FN_OR:  ctrl.aluOp = ALU_OR;
          FN_ADD: ctrl.aluOp = ALU_ADD;
          FN_SUB: ctrl.aluOp = ALU_SUB;
          FN_SLT: ctrl.aluOp = ALU_SLT;
          FN_MUL: begin
            ctrl.aluOp = ALU_MUL;
            ctrl.isMul = 1'b1;
          end
          default: known = 1'b0;
        endcase
      end
      OP_BNE:  if (EN_EXT != 0) bneRaw = 1'b1;           else known = 1'b0;
      OP_ANDI: if (EN_EXT != 0) ctrl = immCtrl(ALU_AND); else known = 1'b0;
      OP_ORI:  if (EN_EXT != 0) ctrl = immCtrl(ALU_OR);  else known = 1'b0;
      OP_SLTI: if (EN_EXT != 0) ctrl = immCtrl(ALU_SLT); else known = 1'b0;
      default: known = 1'b0;
    endcase
    // Partial R-type fills must not leak out of an illegal funct.
    if (!known) begin
      ctrl      = EX_BUBBLE;
      branchRaw = 1'b0;
      bneRaw    = 1'b0;
      jumpRaw   = 1'b0;
    end
  end

  assign branch   = instrValid & branchRaw;
  assign bne      = instrValid & bneRaw;
  assign jump     = instrValid & jumpRaw;
  assign illegal  = instrValid & ~known;
  assign regWrite = ctrl.regWrite;
  assign memToReg = ctrl.memToReg;
  assign memWrite = ctrl.memWrite;
  assign aluSrc   = ctrl.aluSrc;
  assign regDst   = ctrl.regDst;
  assign aluCode  = ctrl.aluOp;
  assign isMul    = ctrl.isMul;

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Decode-stage control with a registered E stage, a multi-cycle multiply
// busy counter and a sticky illegal-instruction flag.
module ctrl_decode_pipe #(
  parameter int ALUCTRL_W = 3,
  parameter int MUL_LAT   = 4,
  parameter int EN_EXT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid_d,
  input  logic [5:0]           op_d,
  input  logic [5:0]           funct_d,
  input  logic                 stall_d,
  input  logic                 flush_e,
  output logic                 branch_d,
  output logic                 bne_d,
  output logic                 jump_d,
  output logic                 reg_write_e,
  output logic                 mem_to_reg_e,
  output logic                 mem_write_e,
  output logic                 alu_src_e,
  output logic                 reg_dst_e,
  output logic [ALUCTRL_W-1:0] alu_ctrl_e,
  output logic                 mul_busy,
  output logic                 illegal_d,
  output logic                 illegal_seen
);
  import mips_pkg::*;

  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  logic                  decRegWrite;
  logic                  decMemToReg;
  logic                  decMemWrite;
  logic                  decAluSrc;
  logic                  decRegDst;
  logic [ALU_CODE_W-1:0] decAluCode;
  logic                  decIsMul;
  logic                  bubble;
  logic                  loadE;
  logic                  mulBusy;

  ctrl_decode_comb #(
    .EN_EXT(EN_EXT)
  ) uDecode (
    .instrValid(instr_valid_d),
    .op        (op_d),
    .funct     (funct_d),
    .branch    (branch_d),
    .bne       (bne_d),
    .jump      (jump_d),
    .illegal   (illegal_d),
    .regWrite  (decRegWrite),
    .memToReg  (decMemToReg),
    .memWrite  (decMemWrite),
    .aluSrc    (decAluSrc),
    .regDst    (decRegDst),
    .aluCode   (decAluCode),
    .isMul     (decIsMul)
  );

  // flush_e is deliberately outranked by mulBusy so an in-flight multiply survives.
  assign bubble = flush_e | stall_d | ~instr_valid_d | illegal_d;
  assign loadE  = ~mulBusy & ~bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      mem_write_e  <= 1'b0;
      alu_src_e    <= 1'b0;
      reg_dst_e    <= 1'b0;
      alu_ctrl_e   <= '0;
    end else if (mulBusy) begin
      reg_write_e  <= reg_write_e;
      mem_to_reg_e <= mem_to_reg_e;
      mem_write_e  <= mem_write_e;
      alu_src_e    <= alu_src_e;
      reg_dst_e    <= reg_dst_e;
      alu_ctrl_e   <= alu_ctrl_e;
    end else if (bubble) begin
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      mem_write_e  <= 1'b0;
      alu_src_e    <= 1'b0;
      reg_dst_e    <= 1'b0;
      alu_ctrl_e   <= '0;
    end else begin
      reg_write_e  <= decRegWrite;
      mem_to_reg_e <= decMemToReg;
      mem_write_e  <= decMemWrite;
      alu_src_e    <= decAluSrc;
      reg_dst_e    <= decRegDst;
      alu_ctrl_e   <= ALUCTRL_W'(decAluCode);
    end
  end

  generate
    if (MUL_LAT > 1) begin : gMulCnt
      logic [CNT_W-1:0] mulCnt;

      // Busy spans counter values MUL_LAT-1 down to 1, i.e. MUL_LAT-1 cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mulCnt <= '0;
        end else if (mulCnt != '0) begin
          mulCnt <= mulCnt - CNT_W'(1);
        end else if (loadE && decIsMul) begin
          mulCnt <= CNT_W'(MUL_LAT - 1);
        end
      end

      assign mulBusy = (mulCnt != '0);
    end else begin : gNoMulCnt
      assign mulBusy = 1'b0;
    end
  endgenerate

  assign mul_busy = mulBusy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (illegal_d) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule
